soc_simple_clk_enable_gen: RTL and testbench

Parametrised clock-enable generator for the 200 MHz PLL output domain. It watches the PLL `locked` flag, debounces it, and produces a qualified `ready`. It then generates NUM_CH independent, runtime-programmable clock-enable pulse trains with programmable divide ratio and phase. This lets SoC peripherals run at derived rates from one PLL clock without more PLL outputs or extra clock domains.

---
 rtl/soc_simple_clk_pkg.sv | 21 ++
 rtl/soc_simple_ce_chan.sv | 69 ++++++
 rtl/soc_simple_clk_enable_gen.sv | 107 ++++++++++
 tb/tb_soc_simple_clk_enable_gen.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/soc_simple_clk_pkg.sv
// Shared types and defaults for the PLL-domain clock-enable generator.
// Holds the lock-FSM state encoding and the per-channel configuration record.
package soc_simple_clk_pkg;

  typedef enum logic [1:0] {
    LK_WAIT = 2'd0,
    LK_QUAL = 2'd1,
    LK_RUN  = 2'd2
  } lock_state_t;

  localparam int NUM_CH_DEF      = 4;
  localparam int DIV_W_DEF       = 16;
  localparam int LOCK_CYCLES_DEF = 1024;
  localparam int DIV_RST_DEF     = 0;

  typedef struct packed {
    logic [DIV_W_DEF-1:0] div;
    logic [DIV_W_DEF-1:0] phase;
  } chan_cfg_t;

endpackage

// File: rtl/soc_simple_ce_chan.sv
// One enable channel: shadow/active div+phase, down-counter and registered ce pulse.
// ce appears one cycle after the counter reaches zero; no backpressure, writes always accepted.
module soc_simple_ce_chan #(
  parameter int DIV_W   = 16,
  parameter int DIV_RST = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             load,
  input  logic             wr,
  input  logic [DIV_W-1:0] wr_div,
  input  logic [DIV_W-1:0] wr_phase,
  output logic             ce
);

  localparam logic [DIV_W-1:0] DIV_INIT = DIV_W'(DIV_RST);
  localparam logic [DIV_W-1:0] ONE      = DIV_W'(1);

  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] phase;
  logic [DIV_W-1:0] sh_div;
  logic [DIV_W-1:0] sh_phase;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] ph_c;
  logic             pend;
  logic             pulse;
  logic             apply;

  // A realignment with zero phase is itself a pulse, so it also commits a pending update.
  always_comb begin
    ph_c  = (phase > div) ? div : phase;
    pulse = run && (load ? (ph_c == '0) : (cnt == '0));
    apply = pend && (pulse || !run);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div      <= DIV_INIT;
      phase    <= '0;
      sh_div   <= DIV_INIT;
      sh_phase <= '0;
      pend     <= 1'b0;
      cnt      <= '0;
      ce       <= 1'b0;
    end else begin
      ce <= pulse;
      if (wr) begin
        sh_div   <= wr_div;
        sh_phase <= (wr_phase > wr_div) ? wr_div : wr_phase;
      end
      if (wr) begin
        pend <= 1'b1;
      end else if (apply) begin
        pend <= 1'b0;
      end
      if (apply) begin
        div   <= sh_div;
        phase <= sh_phase;
      end
      if (pulse) begin
        cnt <= apply ? sh_div : div;
      end else if (run) begin
        cnt <= load ? (ph_c - ONE) : (cnt - ONE);
      end
    end
  end

endmodule

// File: rtl/soc_simple_clk_enable_gen.sv
// PLL lock qualifier plus NUM_CH programmable clock-enable pulse trains on refclk.
// ready/lock_lost react one cycle after the synchronised lock flag; config writes are never stalled.
module soc_simple_clk_enable_gen
  import soc_simple_clk_pkg::*;
#(
  parameter int NUM_CH      = NUM_CH_DEF,
  parameter int DIV_W       = DIV_W_DEF,
  parameter int LOCK_CYCLES = LOCK_CYCLES_DEF,
  parameter int DIV_RST     = DIV_RST_DEF,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              refclk,
  input  logic              rst_n,
  input  logic              pll_locked,
  input  logic              cfg_wr,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [DIV_W-1:0]  cfg_phase,
  input  logic              resync,
  output logic              ready,
  output logic [NUM_CH-1:0] ce,
  output logic              lock_lost
);

  localparam int              LK_W    = $clog2(LOCK_CYCLES + 1);
  localparam logic [LK_W-1:0] LK_LAST = LK_W'(LOCK_CYCLES - 1);
  localparam logic [LK_W-1:0] LK_ONE  = LK_W'(1);

  logic            sync1;
  logic            locked_s;
  lock_state_t     state;
  logic [LK_W-1:0] lk_cnt;
  logic            run_nxt;
  logic            load;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      sync1    <= pll_locked;
      locked_s <= sync1;
    end
  end

  // Channels act on the cycle the FSM enters RUN so the first P=0 pulse lines up with ready.
  always_comb begin
    run_nxt = locked_s && ((state == LK_RUN) || (lk_cnt == LK_LAST));
    load    = run_nxt && ((state != LK_RUN) || resync);
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= LK_WAIT;
      lk_cnt    <= '0;
      ready     <= 1'b0;
      lock_lost <= 1'b0;
    end else begin
      case (state)
        LK_WAIT, LK_QUAL: begin
          if (!locked_s) begin
            state  <= LK_WAIT;
            lk_cnt <= '0;
          end else if (lk_cnt == LK_LAST) begin
            state  <= LK_RUN;
            lk_cnt <= '0;
          end else begin
            state  <= LK_QUAL;
            lk_cnt <= lk_cnt + LK_ONE;
          end
        end
        LK_RUN: begin
          if (!locked_s) begin
            state <= LK_WAIT;
          end
        end
        default: begin
          state  <= LK_WAIT;
          lk_cnt <= '0;
        end
      endcase
      ready <= run_nxt;
      if ((state == LK_RUN) && !locked_s) begin
        lock_lost <= 1'b1;
      end else if (cfg_wr) begin
        lock_lost <= 1'b0;
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    soc_simple_ce_chan #(
      .DIV_W   (DIV_W),
      .DIV_RST (DIV_RST)
    ) u_ch (
      .clk      (refclk),
      .rst_n    (rst_n),
      .run      (run_nxt),
      .load     (load),
      .wr       (cfg_wr && (cfg_ch == CH_W'(i))),
      .wr_div   (cfg_div),
      .wr_phase (cfg_phase),
      .ce       (ce[i])
    );
  end

endmodule

// File: tb/tb_soc_simple_clk_enable_gen.sv
// Directed bench: lock qualification, divide/phase patterns, shadow updates, clamp, lock loss, async reset.
module tb_soc_simple_clk_enable_gen;
  import soc_simple_clk_pkg::*;

  localparam int NCH  = 4;
  localparam int DW   = 16;
  localparam int LC   = 16;
  localparam int DRST = 5;

  logic            refclk = 1'b0;
  logic            rst_n;
  logic            pll_locked;
  logic            cfg_wr;
  logic [1:0]      cfg_ch;
  logic [DW-1:0]   cfg_div;
  logic [DW-1:0]   cfg_phase;
  logic            resync;
  logic            ready;
  logic [NCH-1:0]  ce;
  logic            lock_lost;

  int n_cmp = 0;
  int n_err = 0;
  int td[NCH];
  int tp[NCH];
  logic [NCH-1:0] exp_q[$];

  always #5 refclk = ~refclk;

  soc_simple_clk_enable_gen #(
    .NUM_CH      (NCH),
    .DIV_W       (DW),
    .LOCK_CYCLES (LC),
    .DIV_RST     (DRST)
  ) dut (
    .refclk     (refclk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .cfg_wr     (cfg_wr),
    .cfg_ch     (cfg_ch),
    .cfg_div    (cfg_div),
    .cfg_phase  (cfg_phase),
    .resync     (resync),
    .ready      (ready),
    .ce         (ce),
    .lock_lost  (lock_lost)
  );

  task automatic next();
    @(posedge refclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int clampi(input int p, input int d);
    return (p > d) ? d : p;
  endfunction

  function automatic chan_cfg_t mk(input int d, input int p);
    chan_cfg_t c;
    c.div   = 16'(d);
    c.phase = 16'(p);
    return c;
  endfunction

  task automatic drive_wr(input int ch, input int d, input int p);
    cfg_wr    = 1'b1;
    cfg_ch    = 2'(ch);
    cfg_div   = 16'(d);
    cfg_phase = 16'(p);
  endtask

  task automatic wr_cfg(input int ch, input chan_cfg_t c);
    drive_wr(ch, int'(c.div), int'(c.phase));
    next();
    cfg_wr = 1'b0;
  endtask

  task automatic qualify(input string tag, input int rise);
    for (int c = 0; c < rise; c++) begin
      chk(tag, 32'(ready), 0);
      next();
    end
    chk(tag, 32'(ready), 1);
  endtask

  // Expected ce vectors come from D/P arithmetic; an optional write to channel wch
  // (at window offset wr_at, -1 = together with resync) changes its period after the
  // first pulse that follows the capture edge.
  task automatic run_window(input string tag, input int n, input bit rs, input int wr_at,
                            input int wch, input int nd, input int np);
    logic [NCH-1:0] vec[64];
    logic [NCH-1:0] e;
    for (int k = 0; k < n; k++) vec[k] = '0;
    for (int i = 0; i < NCH; i++) begin
      int d;
      int p;
      d = td[i];
      p = clampi(tp[i], td[i]);
      while (p < n) begin
        vec[p][i] = 1'b1;
        if (i == wch && wr_at >= -1 && p >= wr_at + 2) d = nd;
        p += d + 1;
      end
    end
    for (int k = 0; k < n; k++) exp_q.push_back(vec[k]);
    if (rs) begin
      resync = 1'b1;
      if (wr_at == -1) drive_wr(wch, nd, np);
      next();
      resync = 1'b0;
      cfg_wr = 1'b0;
    end
    for (int k = 0; k < n; k++) begin
      if (k == wr_at) drive_wr(wch, nd, np);
      e = exp_q.pop_front();
      chk(tag, 32'(ce), 32'(e));
      next();
      cfg_wr = 1'b0;
    end
    if (wr_at >= -1) begin
      td[wch] = nd;
      tp[wch] = np;
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    pll_locked = 1'b0;
    cfg_wr     = 1'b0;
    cfg_ch     = '0;
    cfg_div    = '0;
    cfg_phase  = '0;
    resync     = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      td[i] = DRST;
      tp[i] = 0;
    end
    repeat (3) next();
    chk("rst_ready", 32'(ready), 0);
    chk("rst_ce", 32'(ce), 0);
    chk("rst_lost", 32'(lock_lost), 0);
    rst_n = 1'b1;
    next();

    wr_cfg(0, mk(3, 0)); td[0] = 3; tp[0] = 0;
    wr_cfg(1, mk(3, 2)); td[1] = 3; tp[1] = 2;
    wr_cfg(2, mk(0, 0)); td[2] = 0; tp[2] = 0;
    next();

    // Lock with a one-cycle dropout: locked_s returns at cycle 13, ready at 29.
    pll_locked = 1'b1;
    for (int c = 0; c < 29; c++) begin
      if (c == 10) pll_locked = 1'b0;
      if (c == 11) pll_locked = 1'b1;
      chk("qual_glitch", 32'(ready), 0);
      next();
    end
    chk("qual_rise", 32'(ready), 1);
    chk("qual_no_lost", 32'(lock_lost), 0);
    run_window("div_phase", 24, 1'b0, -2, 0, 0, 0);

    wr_cfg(0, mk(7, 0));
    repeat (8) next();
    td[0] = 7;
    run_window("glitch_free", 22, 1'b1, 3, 0, 2, 0);

    wr_cfg(1, mk(4, 9));
    repeat (10) next();
    td[1] = 4; tp[1] = 9;
    run_window("clamp_resync", 16, 1'b1, -1, 3, 1, 0);

    pll_locked = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("loss_hold", 32'(ready), 1);
      if (c == 2) chk("loss_ce_hold", 32'(ce[2]), 1);
      next();
    end
    chk("loss_ready", 32'(ready), 0);
    chk("loss_ce", 32'(ce), 0);
    chk("loss_sticky", 32'(lock_lost), 1);
    next();
    chk("loss_sticky2", 32'(lock_lost), 1);
    wr_cfg(2, mk(0, 0));
    chk("loss_clear", 32'(lock_lost), 0);
    repeat (4) next();

    pll_locked = 1'b1;
    qualify("relock", LC + 2);
    run_window("relock_phase", 12, 1'b0, -2, 0, 0, 0);

    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_ready", 32'(ready), 0);
    chk("arst_ce", 32'(ce), 0);
    chk("arst_lost", 32'(lock_lost), 0);
    next();
    next();
    rst_n = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      td[i] = DRST;
      tp[i] = 0;
    end
    qualify("arst_requal", LC + 2);
    run_window("arst_div_rst", 13, 1'b0, -2, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
